// File: rtl/tile_update_scheduler.sv
// Scans the 16x12 tile tracker once per frame and turns every flagged cell into
// a single draw command on a valid/ready handshake, stalling the scan meanwhile.
module tile_update_scheduler #(
  parameter int COLS = 16,
  parameter int ROWS = 12
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_frame_start,
  input  logic       i_diff,
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic [2:0] i_obj_code,
  output logic       o_scan_en,
  output logic       o_draw_valid,
  input  logic       i_draw_ready,
  output logic [3:0] o_draw_x,
  output logic [3:0] o_draw_y,
  output logic [2:0] o_draw_code,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [7:0] o_update_count,
  output logic       o_overrun,
  output logic       o_sync_err
);

  localparam logic [3:0] LAST_COL    = 4'(COLS - 1);
  localparam logic [3:0] LAST_ROW    = 4'(ROWS - 1);
  localparam logic [7:0] MAX_UPDATES = 8'(COLS * ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_col;
  logic [3:0] r_row;
  logic [7:0] r_run_cnt;
  logic       r_last_cap;
  logic [3:0] r_draw_x;
  logic [3:0] r_draw_y;
  logic [2:0] r_draw_code;
  logic [7:0] r_update_count;
  logic       r_overrun;
  logic       r_sync_err;
  logic       w_last_col;
  logic       w_last_row;
  logic       w_last_cell;

  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_last_cell = w_last_col && w_last_row;

  // State register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_frame_start) w_next = S_SCAN;
        else               w_next = S_IDLE;
      end
      S_SCAN: begin
        if (i_diff)           w_next = S_ISSUE;
        else if (w_last_cell) w_next = S_DONE;
        else                  w_next = S_SCAN;
      end
      S_ISSUE: begin
        if (!i_draw_ready)   w_next = S_ISSUE;
        else if (r_last_cap) w_next = S_DONE;
        else                 w_next = S_SCAN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Scan position, command capture and per-frame update counting
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_col          <= 4'd0;
      r_row          <= 4'd0;
      r_run_cnt      <= 8'd0;
      r_last_cap     <= 1'b0;
      r_draw_x       <= 4'd0;
      r_draw_y       <= 4'd0;
      r_draw_code    <= 3'd0;
      r_update_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_col     <= 4'd0;
            r_row     <= 4'd0;
            r_run_cnt <= 8'd0;
          end
        end
        S_SCAN: begin
          if (w_last_col) begin
            r_col <= 4'd0;
            r_row <= w_last_row ? 4'd0 : r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
          // The tracker advances in this same cycle, so its cell must be latched now
          if (i_diff) begin
            r_draw_x    <= i_x;
            r_draw_y    <= i_y;
            r_draw_code <= i_obj_code;
            r_last_cap  <= w_last_cell;
            if (r_run_cnt < MAX_UPDATES) r_run_cnt <= r_run_cnt + 8'd1;
          end
        end
        S_DONE:  r_update_count <= r_run_cnt;
        default: r_update_count <= r_update_count;
      endcase
    end
  end

  // Overrun pulse and sticky tracker-desync flag
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_overrun <= i_frame_start && (r_state != S_IDLE);
      if ((r_state == S_SCAN) && ((i_x != r_col) || (i_y != r_row))) r_sync_err <= 1'b1;
    end
  end

  assign o_scan_en      = (r_state == S_SCAN);
  assign o_draw_valid   = (r_state == S_ISSUE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_frame_done   = (r_state == S_DONE);
  assign o_draw_x       = r_draw_x;
  assign o_draw_y       = r_draw_y;
  assign o_draw_code    = r_draw_code;
  assign o_update_count = r_update_count;
  assign o_overrun      = r_overrun;
  assign o_sync_err     = r_sync_err;

endmodule

// File: doc/tile_update_scheduler.md
# tile_update_scheduler

Sequences one scan of the 16x12 snake-game tile tracker per game frame. It drives the tracker's `enable` one cell at a time and captures every cell the tracker flags as changed (`diff`). Each change is forwarded as a single draw command to the downstream tile-drawing engine over a valid/ready handshake, and the scan stalls until that command is accepted. It sits between the game-tick logic (`frame_start`) and the display drawing path.

## Interface

Parameters
- `COLS`, 16: grid columns; the column coordinate is 4 bits.
- `ROWS`, 12: grid rows; the row coordinate is 4 bits.

Ports
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse requesting a full-grid scan.
- `diff`  in  1  tracker flag: the current cell changed this cycle.
- `x`  in  4  tracker current column.
- `y`  in  4  tracker current row.
- `obj_code`  in  3  tracker object code for the current cell (0 blank, 1 head, 2 body, 3 apple, 4 border).
- `scan_en`  out  1  tracker enable; combinational, high only in SCAN.
- `draw_valid`  out  1  draw command pending.
- `draw_ready`  in  1  drawing engine accepts the command.
- `draw_x`  out  4  column of the command, held while `draw_valid` is high.
- `draw_y`  out  4  row of the command, held while `draw_valid` is high.
- `draw_code`  out  3  object code of the command, held while `draw_valid` is high.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse when a scan completes.
- `update_count`  out  8  number of draw commands issued in the last completed frame.
- `overrun`  out  1  one-cycle pulse when `frame_start` arrives while `busy` is high.
- `sync_err`  out  1  sticky flag: tracker position disagreed with the internal position during SCAN.

## Operation

States: IDLE, SCAN, ISSUE, DONE.

- **IDLE**
  - `frame_start` goes to SCAN.
  - On that transition: internal `col_cnt`/`row_cnt` are cleared to (0,0) and the running update counter is cleared.
- **SCAN** (`scan_en`=1 every cycle)
  - Every cycle, `(col_cnt,row_cnt)` advances in raster order: column first, wrapping at `COLS-1`, then row.
  - `diff`=0: stay in SCAN, unless this is the last cell (15,11), which goes to DONE.
  - `diff`=1:
    - Register `x`, `y` and `obj_code` into `draw_x`, `draw_y` and `draw_code`.
    - Increment the running counter.
    - Go to ISSUE.
    - The tracker commits the cell and advances in this same cycle.
- **ISSUE** (`scan_en`=0, `draw_valid`=1)
  - Stay until `draw_valid && draw_ready`.
  - Then go to SCAN, or to DONE if the captured cell was (15,11).
- **DONE**
  - `frame_done`=1 for this one cycle.
  - Running counter is copied to `update_count`.
  - Next state is IDLE.
- **`frame_start` while `busy`**
  - The pulse is ignored and `overrun` pulses in the next cycle.
  - The scan in progress is unaffected.
- **`sync_err`**
  - Set in any SCAN cycle where `(x,y) != (col_cnt,row_cnt)`.
  - Cleared only by reset.
- **Running counter**
  - Saturates at 192; it cannot exceed 192 when in sync.
- **`draw_ready` outside ISSUE**
  - Has no effect.

## Timing

- **Reset values:** state IDLE; every output 0, including `draw_x`, `draw_y`, `draw_code`, `update_count` and `sync_err`. Internal counters are 0.
- **Reset mid-frame:** the scan aborts immediately with no `frame_done`. The tracker shares `nrst`, so both restart at (0,0).
- **Frame start:** `frame_start` sampled high in cycle 0 puts the block in SCAN from cycle 1.
- **Cell cost:**
  - A cell with no change costs 1 cycle.
  - A changed cell costs 1 capture cycle plus at least 1 ISSUE cycle.
  - With `draw_ready` held at 1, a changed cell costs exactly 2 cycles.
- **Frame length, no changes:** SCAN covers cycles 1..192, `frame_done` is high in cycle 193, and the block is in IDLE from cycle 194.
- **Frame length, N changes with `draw_ready`=1:** `frame_done` is high in cycle 193+N.
- **Draw outputs:** `draw_x`, `draw_y` and `draw_code` are stable from the first ISSUE cycle through the accepting cycle. `draw_valid` drops the cycle after acceptance.
- **`update_count`:** updates in the DONE cycle and holds until the next DONE.
- **Back-to-back frames:** `frame_start` in the DONE cycle raises `overrun`. `frame_start` in the IDLE cycle after DONE starts a new scan.

## Test plan

- **No changes:** reset, then `frame_start` with `diff` held at 0 -> `scan_en` high for 192 cycles, `frame_done` in cycle 193, `update_count`=0, `draw_valid` never high.
- **Single change, ready always high:** `diff`=1 only at cell (5,3), `obj_code`=3, `draw_ready`=1 -> exactly one command with `draw_x`=5, `draw_y`=3, `draw_code`=3; `frame_done` in cycle 194; `update_count`=1.
- **Backpressure:** change at (0,0) with `draw_ready` held low for 10 cycles -> `draw_valid` and its data held for 11 cycles, `scan_en`=0 throughout, tracker position unchanged; scan resumes at (1,0) after acceptance.
- **Last cell plus overrun:** change at (15,11), and `frame_start` pulsed mid-scan -> after the command is accepted the block goes straight to DONE; `overrun` pulses once; no second scan starts.
- **Desync:** force tracker `x`=2 while the internal position is (1,0) -> `sync_err` is set and stays 1 through later frames until `nrst` is asserted.
- **Reset mid-operation:** assert `nrst` low while in ISSUE -> all outputs 0 asynchronously; the next `frame_start` performs a clean 192-cell scan.
